// File: rtl/dbreak_ctrl_pkg.sv
// Shared types and CPU major-state encodings for the data-break controller.
package dbreak_ctrl_pkg;

  localparam int unsigned MS_W   = 5;
  localparam int unsigned DATA_W = 12;

  // CPU major-state encodings as seen on the state bus
  localparam logic [MS_W-1:0] F1  = 5'b00001;
  localparam logic [MS_W-1:0] DB0 = 5'b00100;
  localparam logic [MS_W-1:0] DB1 = 5'b01000;
  localparam logic [MS_W-1:0] DB2 = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2,
    ST_DONE = 2'd3
  } dbstate_t;

endpackage

// File: rtl/dbreak_ctrl.sv
// Data-break controller: turns disk-engine requests into CPU data-break cycles.
// Optional REQ watchdog enabled by defining DBREAK_TIMEOUT_EN.
module dbreak_ctrl
  import dbreak_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic [MS_W-1:0]   state,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              dmaREQ,
  input  logic              dmaRD,
  input  logic              dmaWR,
  input  logic [ADDR_W-1:0] dmaADDR,
  input  logic [DATA_W-1:0] dmaDOUT,
  output logic              dmaGNT,
  output logic [DATA_W-1:0] dmaDIN,
  output logic              data_break,
  output logic [ADDR_W-1:0] break_addr,
  output logic [DATA_W-1:0] break_data,
  output logic              break_wr,
  output logic              db_err
);

  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("dbreak_ctrl: TIMEOUT_CYC out of range");
  end

  dbstate_t          st_q;
  logic              data_break_q;
  logic              gnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              wr_q;
  logic [DATA_W-1:0] din_q;
  logic              req_ok_c;
  logic              wd_expire_c;

  // Only a request with exactly one direction bit set is accepted
  assign req_ok_c = dmaREQ & (dmaRD ^ dmaWR);

`ifdef DBREAK_TIMEOUT_EN
  localparam int unsigned   WD_W    = 16;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic [WD_W-1:0] wd_cnt_d;
  logic            db_err_q;

  // Counts cycles spent in REQ; DB1 in the same cycle wins over expiry
  assign wd_cnt_d    = (st_q == ST_REQ) ? wd_cnt_q + WD_W'(1) : '0;
  assign wd_expire_c = (st_q == ST_REQ) && (state != DB1) && (wd_cnt_q == WD_LAST);
  assign db_err      = db_err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      db_err_q <= 1'b0;
    end else if (clear) begin
      wd_cnt_q <= '0;
      db_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (wd_expire_c) db_err_q <= 1'b1;
    end
  end
`else
  assign wd_expire_c = 1'b0;
  assign db_err      = 1'b0;
`endif

  // Break sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q         <= ST_IDLE;
      data_break_q <= 1'b0;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      wr_q         <= 1'b0;
      din_q        <= '0;
    end else if (clear) begin
      st_q         <= ST_IDLE;
      data_break_q <= 1'b0;
      gnt_q        <= 1'b0;
    end else begin
      case (st_q)
        ST_IDLE: begin
          if (req_ok_c) begin
            st_q         <= ST_REQ;
            addr_q       <= dmaADDR;
            data_q       <= dmaDOUT;
            wr_q         <= dmaWR;
            data_break_q <= 1'b1;
          end
        end
        ST_REQ: begin
          if (state == DB1) begin
            st_q         <= ST_XFER;
            data_break_q <= 1'b0;
          end else if (wd_expire_c) begin
            st_q         <= ST_DONE;
            gnt_q        <= 1'b1;
            data_break_q <= 1'b0;
            if (!wr_q) din_q <= '0;
          end
        end
        ST_XFER: begin
          // A DB2 seen before DB1 never reaches here, so it is ignored
          if (state == DB2) begin
            st_q  <= ST_DONE;
            gnt_q <= 1'b1;
            if (!wr_q) din_q <= mem_rdata;
          end
        end
        ST_DONE: begin
          st_q  <= ST_IDLE;
          gnt_q <= 1'b0;
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  assign dmaGNT     = gnt_q;
  assign dmaDIN     = din_q;
  assign data_break = data_break_q;
  assign break_addr = addr_q;
  assign break_data = data_q;
  assign break_wr   = wr_q;

endmodule

// File: tb/tb_dbreak_ctrl.sv
// Scoreboard bench for dbreak_ctrl; grant payloads are checked against queued expectations.
module tb_dbreak_ctrl;
  import dbreak_ctrl_pkg::*;

  logic        clk;
  logic        reset;
  logic        clear;
  logic [4:0]  state;
  logic [11:0] mem_rdata;
  logic        dmaREQ, dmaRD, dmaWR;
  logic [14:0] dmaADDR;
  logic [11:0] dmaDOUT;
  logic        dmaGNT;
  logic [11:0] dmaDIN;
  logic        data_break;
  logic [14:0] break_addr;
  logic [11:0] break_data;
  logic        break_wr;
  logic        db_err;

  dbreak_ctrl #(.TIMEOUT_CYC(16), .ADDR_W(15)) dut (
    .clk(clk), .reset(reset), .clear(clear), .state(state), .mem_rdata(mem_rdata),
    .dmaREQ(dmaREQ), .dmaRD(dmaRD), .dmaWR(dmaWR), .dmaADDR(dmaADDR), .dmaDOUT(dmaDOUT),
    .dmaGNT(dmaGNT), .dmaDIN(dmaDIN), .data_break(data_break), .break_addr(break_addr),
    .break_data(break_data), .break_wr(break_wr), .db_err(db_err)
  );

  typedef struct {
    logic [14:0] addr;
    logic [11:0] data;
    logic        wr;
    logic        chk_din;
    logic [11:0] din;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_run   = 0;
  int   n_fail  = 0;
  int   n_push  = 0;
  int   n_gnt   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input logic [14:0] addr, input logic [11:0] data, input logic wr,
                            input logic chk_din, input logic [11:0] din, input logic err);
    exp_t e;
    e.addr = addr; e.data = data; e.wr = wr; e.chk_din = chk_din; e.din = din; e.err = err;
    exp_q.push_back(e);
    n_push++;
  endtask

  task automatic req_on(input logic wr, input logic [14:0] addr, input logic [11:0] dout);
    dmaREQ = 1'b1; dmaWR = wr; dmaRD = ~wr; dmaADDR = addr; dmaDOUT = dout;
  endtask

  // Walk the CPU through DB0, DB1, a gap, then DB2; optionally a stray DB2 first
  task automatic pump(input logic early_db2, input logic [11:0] rdata);
    state = DB0;
    cyc(1);
    chk("brk_before_db1", 32'(data_break), 32'd1);
    if (early_db2) begin
      state = DB2;
      cyc(2);
      chk("early_db2_ignored", 32'(data_break), 32'd1);
    end
    state = DB1;
    cyc(1);
    chk("brk_clr_db1", 32'(data_break), 32'd0);
    state = DB0;
    cyc(1);
    chk("no_gnt_before_db2", 32'(dmaGNT), 32'd0);
    state = DB2; mem_rdata = rdata;
    cyc(1);
    chk("gnt_after_db2", 32'(dmaGNT), 32'd1);
    state = F1; mem_rdata = 12'o7777;
  endtask

  // Scoreboard: every grant must match the oldest queued expectation
  always @(negedge clk) begin
    if (dmaGNT) begin
      n_gnt++;
      if (exp_q.size() == 0) begin
        chk("gnt_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_addr", 32'(break_addr), 32'(e.addr));
        chk("sb_data", 32'(break_data), 32'(e.data));
        chk("sb_wr", 32'(break_wr), 32'(e.wr));
        chk("sb_err", 32'(db_err), 32'(e.err));
        if (e.chk_din) chk("sb_din", 32'(dmaDIN), 32'(e.din));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL tb_timeout: got hang expected finish");
    $fatal(1);
  end

  initial begin
    int bad;
    reset = 1'b0; clear = 1'b0; state = F1; mem_rdata = 12'o7777;
    dmaREQ = 1'b0; dmaRD = 1'b0; dmaWR = 1'b0; dmaADDR = '0; dmaDOUT = '0;

    #12;
    chk("rst_brk", 32'(data_break), 32'd0);
    chk("rst_gnt", 32'(dmaGNT), 32'd0);
    chk("rst_addr", 32'(break_addr), 32'd0);
    chk("rst_data", 32'(break_data), 32'd0);
    chk("rst_wr", 32'(break_wr), 32'd0);
    chk("rst_din", 32'(dmaDIN), 32'd0);
    chk("rst_err", 32'(db_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(2);

    // Write transfer
    req_on(1'b1, 15'o12345, 12'o7070);
    expect_gnt(15'o12345, 12'o7070, 1'b1, 1'b0, 12'o0, 1'b0);
    cyc(1);
    chk("wr_brk", 32'(data_break), 32'd1);
    chk("wr_addr", 32'(break_addr), 32'(15'o12345));
    chk("wr_data", 32'(break_data), 32'(12'o7070));
    chk("wr_dir", 32'(break_wr), 32'd1);
    pump(1'b0, 12'o0);
    dmaREQ = 1'b0;
    cyc(1);
    chk("wr_gnt_pulse", 32'(dmaGNT), 32'd0);
    cyc(2);
    chk("wr_no_rerun", 32'(data_break), 32'd0);

    // Read transfer
    req_on(1'b0, 15'o00200, 12'o0);
    expect_gnt(15'o00200, 12'o0, 1'b0, 1'b1, 12'o4321, 1'b0);
    cyc(1);
    chk("rd_dir", 32'(break_wr), 32'd0);
    pump(1'b0, 12'o4321);
    chk("rd_din", 32'(dmaDIN), 32'(12'o4321));
    dmaREQ = 1'b0;
    cyc(2);

    // DB2 before DB1 must not advance the FSM
    req_on(1'b0, 15'o00210, 12'o0);
    expect_gnt(15'o00210, 12'o0, 1'b0, 1'b1, 12'o6543, 1'b0);
    cyc(1);
    pump(1'b1, 12'o6543);
    dmaREQ = 1'b0;
    cyc(2);

    // Illegal direction combinations
    dmaREQ = 1'b1; dmaRD = 1'b1; dmaWR = 1'b1; dmaADDR = 15'o07777;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (data_break || dmaGNT) bad++;
    end
    chk("illegal_both", 32'(bad), 32'd0);
    dmaRD = 1'b0; dmaWR = 1'b0;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      if (data_break || dmaGNT) bad++;
    end
    chk("illegal_none", 32'(bad), 32'd0);
    chk("illegal_addr_kept", 32'(break_addr), 32'(15'o00210));
    dmaREQ = 1'b0;
    cyc(1);

    // clear during XFER, colliding with DB2
    req_on(1'b1, 15'o00400, 12'o1234);
    cyc(1);
    state = DB1;
    cyc(1);
    clear = 1'b1; state = DB2; dmaREQ = 1'b0;
    cyc(1);
    clear = 1'b0; state = F1;
    chk("clr_gnt", 32'(dmaGNT), 32'd0);
    chk("clr_brk", 32'(data_break), 32'd0);
    cyc(3);
    chk("clr_no_late_gnt", 32'(dmaGNT), 32'd0);

    // Asynchronous reset while in REQ
    req_on(1'b1, 15'o00500, 12'o5555);
    cyc(1);
    chk("rstm_brk_set", 32'(data_break), 32'd1);
    dmaREQ = 1'b0;
    reset = 1'b0;
    #1;
    chk("rstm_brk_async", 32'(data_break), 32'd0);
    chk("rstm_addr", 32'(break_addr), 32'd0);
    #2;
    reset = 1'b1;
    cyc(3);
    chk("rstm_idle", 32'(data_break), 32'd0);

    // Back-to-back: request held across the grant, address changed after it
    req_on(1'b0, 15'o00200, 12'o0);
    expect_gnt(15'o00200, 12'o0, 1'b0, 1'b1, 12'o1111, 1'b0);
    cyc(1);
    pump(1'b0, 12'o1111);
    cyc(1);
    chk("b2b_gnt_low", 32'(dmaGNT), 32'd0);
    chk("b2b_idle_brk", 32'(data_break), 32'd0);
    dmaADDR = 15'o00201;
    expect_gnt(15'o00201, 12'o0, 1'b0, 1'b1, 12'o2222, 1'b0);
    cyc(1);
    chk("b2b_brk", 32'(data_break), 32'd1);
    chk("b2b_addr", 32'(break_addr), 32'(15'o00201));
    pump(1'b0, 12'o2222);
    dmaREQ = 1'b0;
    cyc(2);

`ifdef DBREAK_TIMEOUT_EN
    begin
      int lat;
      bit found;
      req_on(1'b0, 15'o00300, 12'o0);
      expect_gnt(15'o00300, 12'o0, 1'b0, 1'b1, 12'o0, 1'b1);
      cyc(1);
      lat = 0; found = 1'b0;
      for (int k = 1; k <= 40 && !found; k++) begin
        cyc(1);
        if (dmaGNT) begin found = 1'b1; lat = k; end
      end
      chk("wd_latency", 32'(lat), 32'd16);
      chk("wd_err", 32'(db_err), 32'd1);
      chk("wd_din", 32'(dmaDIN), 32'd0);
      chk("wd_brk", 32'(data_break), 32'd0);
      dmaREQ = 1'b0;
      cyc(3);
      chk("wd_err_sticky", 32'(db_err), 32'd1);
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      chk("wd_err_clr", 32'(db_err), 32'd0);
    end
`else
    req_on(1'b0, 15'o00300, 12'o0);
    cyc(1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(1);
      if (!data_break || dmaGNT) bad++;
    end
    chk("nowd_hold", 32'(bad), 32'd0);
    chk("nowd_err", 32'(db_err), 32'd0);
    dmaREQ = 1'b0; clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("nowd_clr", 32'(data_break), 32'd0);
`endif

    cyc(3);
    chk("gnt_count", 32'(n_gnt), 32'(n_push));
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
